fifo_umbral_param: RTL and testbench

Parametrised synchronous FIFO with programmable almost-empty/almost-full thresholds, occupancy count, flush, and overflow/underflow error reporting. It is the generalised successor of the team's fixed 4-bit/8-entry threshold FIFO and serves as the per-class buffer in the QoS path, where the thresholds drive flow-control decisions.

---
 rtl/fifo_umbral_param.sv | 126 ++++++++++++
 tb/tb_fifo_umbral_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbral_param.sv
// rtl/fifo_umbral_param.sv - parametrised FIFO with programmable almost-empty/almost-full thresholds
module fifo_umbral_param #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  FLUSH,
  input  logic [DATA_WIDTH-1:0] DATO_IN,
  input  logic [ADDR_WIDTH:0]   TL,
  input  logic [ADDR_WIDTH:0]   TH,
  output logic [DATA_WIDTH-1:0] DATO_OUT,
  output logic                  VALID_OUT,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic                  ERROR
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dato_q, dato_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  err_q, err_d;
  logic                  full, empty, rd_ok, wr_ok, wr_en;

  // Accept/reject decisions and next-state for pointers, occupancy and read port
  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    rd_ok   = POP && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    wr_ok   = PUSH && (!full || rd_ok);
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    dato_d  = dato_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (FLUSH) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      wr_en = wr_ok;
      if (wr_ok) begin
        wp_d = wp_q + ADDR_WIDTH'(1);
      end
      if (rd_ok) begin
        rp_d    = rp_q + ADDR_WIDTH'(1);
        dato_d  = mem_q[rp_q];
        valid_d = 1'b1;
      end
      ovf_d = PUSH && !wr_ok;
      udf_d = POP && empty;
      err_d = err_q || ovf_d || udf_d;
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control and read-port registers, cleared immediately on reset
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      dato_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dato_q  <= dato_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset and flush
  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem_q[wp_q] <= DATO_IN;
    end
  end

  // Flags follow the registered occupancy; thresholds are live inputs
  always_comb begin
    DATO_OUT     = dato_q;
    VALID_OUT    = valid_q;
    COUNT        = count_q;
    EMPTY        = (count_q == '0);
    FULL         = (count_q == DEPTH_C);
    ALMOST_EMPTY = (count_q <= TL);
    ALMOST_FULL  = (count_q >= TH);
    OVERFLOW     = ovf_q;
    UNDERFLOW    = udf_q;
    ERROR        = err_q;
  end

endmodule

// File: tb/tb_fifo_umbral_param.sv
// tb/tb_fifo_umbral_param.sv - table-driven self-checking bench for fifo_umbral_param
module tb_fifo_umbral_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-size instance
  logic       rst_a, push_a, pop_a, flush_a;
  logic [3:0] din_a, tl_a, th_a, dout_a, cnt_a;
  logic       val_a, emp_a, ful_a, ae_a, af_a, ovf_a, udf_a, err_a;

  // 8-bit x 16-entry instance
  logic       rst_b, push_b, pop_b, flush_b;
  logic [7:0] din_b, dout_b;
  logic [4:0] tl_b, th_b, cnt_b;
  logic       val_b, emp_b, ful_b, ae_b, af_b, ovf_b, udf_b, err_b;

  fifo_umbral_param #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut_a (
    .CLOCK(clk), .RESET(rst_a), .PUSH(push_a), .POP(pop_a), .FLUSH(flush_a),
    .DATO_IN(din_a), .TL(tl_a), .TH(th_a), .DATO_OUT(dout_a), .VALID_OUT(val_a),
    .COUNT(cnt_a), .EMPTY(emp_a), .FULL(ful_a), .ALMOST_EMPTY(ae_a),
    .ALMOST_FULL(af_a), .OVERFLOW(ovf_a), .UNDERFLOW(udf_a), .ERROR(err_a)
  );

  fifo_umbral_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut_b (
    .CLOCK(clk), .RESET(rst_b), .PUSH(push_b), .POP(pop_b), .FLUSH(flush_b),
    .DATO_IN(din_b), .TL(tl_b), .TH(th_b), .DATO_OUT(dout_b), .VALID_OUT(val_b),
    .COUNT(cnt_b), .EMPTY(emp_b), .FULL(ful_b), .ALMOST_EMPTY(ae_b),
    .ALMOST_FULL(af_b), .OVERFLOW(ovf_b), .UNDERFLOW(udf_b), .ERROR(err_b)
  );

  typedef struct {
    logic       push, pop, flush;
    logic [3:0] din;
    logic [3:0] e_count;
    logic       e_valid;
    logic [3:0] e_dout;
    logic       e_ovf, e_udf, e_err;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(int p, int po, int f, int d, int c, int v, int o,
                              int ov, int un, int er);
    vec_t t;
    t.push = p[0];   t.pop = po[0];   t.flush = f[0];
    t.din = d[3:0];  t.e_count = c[3:0];  t.e_valid = v[0];
    t.e_dout = o[3:0];  t.e_ovf = ov[0];  t.e_udf = un[0];  t.e_err = er[0];
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(logic p, logic po, logic f, logic [3:0] d);
    push_a = p; pop_a = po; flush_a = f; din_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(logic p, logic po, logic [7:0] d);
    push_b = p; pop_b = po; din_b = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pv[8];
    int ev;
    pv = '{1, 2, 6, 0, 1, 8, 11, 13};

    rst_a = 1'b1; push_a = 1'b0; pop_a = 1'b0; flush_a = 1'b0; din_a = '0;
    tl_a = 4'd2; th_a = 4'd6;
    rst_b = 1'b1; push_b = 1'b0; pop_b = 1'b0; flush_b = 1'b0; din_b = '0;
    tl_b = 5'd2; th_b = 5'd12;

    // fill with the reference pattern, then overflow
    for (int i = 0; i < 8; i++) add(1, 0, 0, pv[i], i + 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 15, 8, 0, 0, 1, 0, 1);
    // drain in order, then underflow with DATO_OUT held
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 7 - i, 1, pv[i], 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 13, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 13, 0, 0, 1);
    // four words, then streaming push+pop across the pointer wrap
    for (int i = 1; i <= 4; i++) add(1, 0, 0, i, i, 0, 13, 0, 0, 1);
    for (int k = 0; k < 10; k++) add(1, 1, 0, 5 + k, 4, 1, 1 + k, 0, 0, 1);
    // top up to full, push+pop while full
    for (int i = 0; i < 4; i++) add(1, 0, 0, (15 + i) % 16, 5 + i, 0, 10, 0, 0, 1);
    add(1, 1, 0, 3, 8, 1, 11, 0, 0, 1);
    begin
      int ord[8];
      ord = '{12, 13, 14, 15, 0, 1, 2, 3};
      for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 7 - i, 1, ord[i], 0, 0, 1);
    end
    // push+pop while empty: pop underflows, push lands
    add(1, 1, 0, 7, 1, 0, 3, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 7, 0, 0, 1);
    // five words then flush with push and pop asserted
    for (int i = 1; i <= 5; i++) add(1, 0, 0, i, i, 0, 7, 0, 0, 1);
    add(1, 1, 1, 9, 0, 0, 7, 0, 0, 1);
    add(1, 0, 0, 10, 1, 0, 7, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 10, 0, 0, 1);

    #3;
    chk("reset count", 32'(cnt_a), 32'd0);
    chk("reset valid", 32'(val_a), 32'd0);
    chk("reset dout", 32'(dout_a), 32'd0);
    chk("reset error", 32'(err_a), 32'd0);
    chk("reset empty", 32'(emp_a), 32'd1);
    chk("reset full", 32'(ful_a), 32'd0);
    chk("reset almost_empty", 32'(ae_a), 32'd1);
    chk("reset almost_full", 32'(af_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step_a(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
      chk($sformatf("v%0d count", i), 32'(cnt_a), 32'(vecs[i].e_count));
      chk($sformatf("v%0d valid", i), 32'(val_a), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d dout", i), 32'(dout_a), 32'(vecs[i].e_dout));
      chk($sformatf("v%0d overflow", i), 32'(ovf_a), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d underflow", i), 32'(udf_a), 32'(vecs[i].e_udf));
      chk($sformatf("v%0d error", i), 32'(err_a), 32'(vecs[i].e_err));
      chk($sformatf("v%0d empty", i), 32'(emp_a), 32'(vecs[i].e_count == 4'd0));
      chk($sformatf("v%0d full", i), 32'(ful_a), 32'(vecs[i].e_count == 4'd8));
      chk($sformatf("v%0d almost_empty", i), 32'(ae_a), 32'(vecs[i].e_count <= 4'd2));
      chk($sformatf("v%0d almost_full", i), 32'(af_a), 32'(vecs[i].e_count >= 4'd6));
    end

    // asynchronous reset landing between edges in the middle of a burst
    step_a(1'b1, 1'b0, 1'b0, 4'd1);
    step_a(1'b1, 1'b0, 1'b0, 4'd2);
    chk("pre-reset count", 32'(cnt_a), 32'd2);
    #2 rst_a = 1'b1;
    #1;
    chk("async count", 32'(cnt_a), 32'd0);
    chk("async error", 32'(err_a), 32'd0);
    chk("async empty", 32'(emp_a), 32'd1);
    chk("async valid", 32'(val_a), 32'd0);
    chk("async dout", 32'(dout_a), 32'd0);
    chk("async almost_full", 32'(af_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    step_a(1'b1, 1'b0, 1'b0, 4'd5);
    chk("post-reset count", 32'(cnt_a), 32'd1);
    step_a(1'b0, 1'b1, 1'b0, 4'd0);
    chk("post-reset dout", 32'(dout_a), 32'd5);
    chk("post-reset valid", 32'(val_a), 32'd1);

    // TH=0 and TL=DEPTH force both almost flags at every occupancy
    step_a(1'b0, 1'b0, 1'b0, 4'd0);
    th_a = 4'd0; tl_a = 4'd8;
    #1;
    for (int c = 0; c <= 8; c++) begin
      chk($sformatf("sweep af c=%0d", c), 32'(af_a), 32'd1);
      chk($sformatf("sweep ae c=%0d", c), 32'(ae_a), 32'd1);
      chk($sformatf("sweep count c=%0d", c), 32'(cnt_a), 32'(c));
      if (c < 8) step_a(1'b1, 1'b0, 1'b0, 4'(c));
    end
    th_a = 4'd6; tl_a = 4'd2;

    // wide instance: FULL only at 16 entries, then overflow, then ordered drain
    for (int i = 0; i < 16; i++) begin
      step_b(1'b1, 1'b0, 8'(i * 17));
      chk($sformatf("b count %0d", i), 32'(cnt_b), 32'(i + 1));
      chk($sformatf("b full %0d", i), 32'(ful_b), 32'(i == 15));
    end
    step_b(1'b1, 1'b0, 8'hAA);
    chk("b overflow", 32'(ovf_b), 32'd1);
    chk("b error", 32'(err_b), 32'd1);
    chk("b count held", 32'(cnt_b), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step_b(1'b0, 1'b1, 8'd0);
      ev = (i * 17) % 256;
      chk($sformatf("b dout %0d", i), 32'(dout_b), 32'(ev));
    end
    chk("b empty", 32'(emp_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
